// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: command handshake, status pulses and open-collector pin controls.
// The slave modport is the transmitter; the master modport is its user plus the pin pads.
interface ps2_host_tx_if;
    logic [7:0] data;
    logic       send;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output data, send, ps2_clk_in, ps2_dat_in,
        input  ready, busy, done, err, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  data, send, ps2_clk_in, ps2_dat_in,
        output ready, busy, done, err, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, odd-parity shift, ACK check.
// Define PS2_TX_RETRY_EN to resend the latched byte once after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave bus
);
    localparam int PH_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int CNT_W  = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_fe;

    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_edge;
    logic [9:0]       r_frame;
    logic             r_bit_oe;
    logic             r_nack;
    logic             r_done;
    logic             r_err;

    logic w_in_frame;
    logic w_phase_end;
    logic w_to_expire;
    logic w_shift;
    logic w_fail;
    logic w_done_set;
    logic w_err_set;

`ifdef PS2_TX_RETRY_EN
    logic [7:0] r_data;
    logic       r_retried;
    logic       w_retry;
`endif

    // Stop bit, odd parity, then data; shifted out from bit 0.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

    // Pin synchronizers; idle lines are high, so reset to 1 keeps the edge detector quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= bus.ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fe       = r_clk_prev & ~r_clk_s2;
    assign w_in_frame = (r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
    assign w_to_expire = w_in_frame && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_shift    = (r_state == ST_SHIFT) && w_fe && !w_to_expire;

    always_comb begin
        w_phase_end = 1'b0;
        if (r_state == ST_INHIBIT) begin
            w_phase_end = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));
        end else if (r_state == ST_START) begin
            w_phase_end = (r_cnt == CNT_W'(START_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout is tested before any edge so an expiring counter always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.send) w_state_nxt = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                if (w_phase_end) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_phase_end) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_to_expire) begin
                    w_fail = 1'b1;
                end else if (w_fe && (r_edge == 4'd9)) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_to_expire) begin
                    w_fail = 1'b1;
                end else if (w_fe) begin
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_to_expire) begin
                    w_fail = 1'b1;
                end else if (r_clk_s2 && r_dat_s2) begin
                    if (r_nack) begin
                        w_fail = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_set  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!r_retried) begin
                w_state_nxt = ST_INHIBIT;
                w_retry     = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
                w_err_set   = 1'b1;
            end
`else
            w_state_nxt = ST_IDLE;
            w_err_set   = 1'b1;
`endif
        end
    end

    always_comb begin
        bus.ready      = (r_state == ST_IDLE);
        bus.busy       = (r_state != ST_IDLE);
        bus.done       = r_done;
        bus.err        = r_err;
        bus.ps2_clk_oe = (r_state == ST_INHIBIT) || (r_state == ST_START);
        case (r_state)
            ST_START: bus.ps2_dat_oe = 1'b1;
            ST_SHIFT: bus.ps2_dat_oe = r_bit_oe;
            default:  bus.ps2_dat_oe = 1'b0;
        endcase
    end

    // Phase, timeout and bit counters plus the registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_to_cnt <= '0;
            r_edge   <= '0;
            r_bit_oe <= 1'b0;
            r_nack   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_INHIBIT) || (r_state == ST_START)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == ST_START) begin
                r_to_cnt <= '0;
            end else if (w_in_frame) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            // The start bit stays on the line until the device's first falling edge.
            if (r_state == ST_START) begin
                r_edge   <= '0;
                r_bit_oe <= 1'b1;
            end else if (w_shift) begin
                r_edge   <= r_edge + 4'd1;
                r_bit_oe <= ~r_frame[0];
            end

            if ((r_state == ST_ACK) && w_fe && !w_to_expire) begin
                r_nack <= r_dat_s2;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retried <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_retried <= 1'b0;
        end else if (w_retry) begin
            r_retried <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && bus.send) begin
            r_frame <= frame_of(bus.data);
`ifdef PS2_TX_RETRY_EN
        end else if (w_retry) begin
            r_frame <= frame_of(r_data);
`endif
        end else if (w_shift) begin
            r_frame <= {1'b0, r_frame[9:1]};
        end
`ifdef PS2_TX_RETRY_EN
        if ((r_state == ST_IDLE) && bus.send) begin
            r_data <= bus.data;
        end
`endif
    end
endmodule
